apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
APB4 requester (completer-facing master) that converts a simple valid/ready command stream into single APB transfers, one at a time. It drives psel/penable/paddr/pwrite/pwdata/pstrb/pprot toward our APB register slaves. It returns prdata/pslverr on a one-entry valid/ready response channel. It sits between an internal controller (CPU shim or test sequencer) and the APB peripheral bus.

Parameters:
DATA_WIDTH, 32, APB data width; must be a multiple of 8
ADDR_WIDTH, 32, APB address width
TIMEOUT_CYCLES, 256, ACCESS-phase wait limit; used only with APB_MASTER_TIMEOUT_EN

Ports:
pclk  in  1  clock
preset  in  1  asynchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  write byte strobes
cmd_prot  in  3  protection attributes
rsp_valid  out  1  response held
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_err  out  1  pslverr, or timeout
paddr  out  ADDR_WIDTH  APB address
pprot  out  3  APB protection
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes
pready  in  1  completer ready
prdata  in  DATA_WIDTH  completer read data
pslverr  in  1  completer error

Behaviour:
- Reset (preset=1, async): state=IDLE. psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, rsp_rdata, rsp_err all 0. cmd_ready=0 while in reset. Reset mid-transfer aborts immediately; no response is produced.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready = ~rsp_valid | rsp_ready (combinational). On accept, register addr/write/wdata/prot, and strb (forced to 0 for reads). Go to SETUP.
- SETUP (1 cycle): psel=1, penable=0, APB outputs driven from the registered command. Unconditionally go to ACCESS.
- ACCESS: psel=1, penable=1. All APB outputs are held stable until pready=1.
  - On pready=1: capture rsp_rdata = pwrite ? 0 : prdata, and rsp_err = pslverr. Set rsp_valid=1, drop psel/penable, go to IDLE.
- Latency: accept at edge N → SETUP cycle N+1 → ACCESS cycle N+2 → with zero-wait completer, rsp_valid=1 from cycle N+3. Each pready-low cycle adds one cycle.
- Response slot: rsp_valid stays high until rsp_ready. Response data is stable while rsp_valid=1.
- Simultaneous consume + accept in IDLE is allowed: rsp_valid clears that edge and the new command enters SETUP. A new response cannot overwrite an unconsumed one, because commands are only accepted when the slot is free or draining.
- cmd_ready=0 in SETUP and ACCESS; at most one outstanding transfer.
- psel never deasserts during a transfer. penable is high only in ACCESS.
- APB outputs are registered; no combinational path from pready to any APB output.
- Address is passed through unmodified; alignment is the completer's responsibility.

Optional Feature:
APB_MASTER_TIMEOUT_EN.
- Defined: a wait counter (width $clog2(TIMEOUT_CYCLES+1)) clears on SETUP and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES, the transfer is abandoned: psel/penable drop, rsp_valid=1, rsp_err=1, rsp_rdata=0, go to IDLE.
  - If pready=1 on the same cycle as the limit is reached, the real completion wins.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Test Plan:
- Write: cmd addr=0x08 wdata=0xDEADBEEF strb=0xF, completer pready=1 → SETUP at N+1 (psel=1, penable=0), ACCESS at N+2 with stable pwdata, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read: cmd read addr=0x0C, completer returns prdata=0x00000003 → pstrb=0 throughout, rsp_rdata=0x3, rsp_err=0.
- Wait states: pready low for 3 ACCESS cycles → paddr/pwrite/pwdata unchanged across all 4 ACCESS cycles, rsp_valid at N+6.
- Error: read addr=0x40 with completer pslverr=1 in ACCESS → rsp_err=1. Then a following good write completes with rsp_err=0.
- Backpressure/back-to-back: hold rsp_ready=0 after a response → cmd_ready=0 and psel stays 0. Raise rsp_ready with a queued cmd_valid → consume and accept on the same edge, next SETUP immediately.
- Reset/timeout: assert preset during ACCESS → psel=penable=rsp_valid=0 immediately. With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4 and pready stuck 0 → rsp_err=1, rsp_rdata=0 after 4 wait cycles.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB4 requester: turns a valid/ready command stream into single APB transfers and returns a one-entry response.
// Optional ACCESS-phase timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [2:0]              pprot,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [2:0]              pprot_q, pprot_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
  localparam int unused_timeout_lp = TIMEOUT_CYCLES;
`endif

  // Slot is free or draining this edge; never ready while in reset or mid-transfer.
  assign cmd_ready = ~preset & (state_q == IDLE) & (~rsp_valid_q | rsp_ready);

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pprot_d     = pprot_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          paddr_d   = cmd_addr;
          pprot_d   = cmd_prot;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          pstrb_d   = cmd_write ? cmd_strb : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          state_d     = IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
        end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This wait cycle brings the count to the limit: abandon with an error.
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_cnt_d  = wait_cnt_q + CNT_W'(1);
`endif
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pprot_q     <= 3'b000;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pprot_q     <= pprot_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign paddr     = paddr_q;
  assign pprot     = pprot_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge; the APB completer is driven directly from the stimulus.
module tb_apb_master_bridge;

  logic        pclk;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int tests_run    = 0;
  int tests_failed = 0;

  apb_master_bridge #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Present one command, confirm it is accepted at the next edge, then withdraw it.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot);
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
    cmd_valid = 1'b1;
    check("issue_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("consume_valid", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    preset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    cmd_strb = 4'h0; cmd_prot = 3'b000; rsp_ready = 1'b0; pready = 1'b0;
    prdata = 32'h0; pslverr = 1'b0;
    repeat (2) tick();
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    preset = 1'b0; cmd_valid = 1'b0;
    tick();

    // Write, zero-wait completer; prdata is nonzero so rdata must be forced to 0.
    pready = 1'b1; prdata = 32'h1234_5678;
    issue(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 3'b010);
    check("wr_setup_psel", 64'(psel), 64'd1);
    check("wr_setup_penable", 64'(penable), 64'd0);
    check("wr_setup_paddr", 64'(paddr), 64'h8);
    check("wr_setup_pwrite", 64'(pwrite), 64'd1);
    check("wr_setup_pstrb", 64'(pstrb), 64'hF);
    check("wr_setup_pprot", 64'(pprot), 64'h2);
    check("wr_setup_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    check("wr_access_penable", 64'(penable), 64'd1);
    check("wr_access_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    check("wr_access_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    check("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    check("wr_rsp_err", 64'(rsp_err), 64'd0);
    check("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("wr_done_psel", 64'(psel), 64'd0);
    check("wr_done_penable", 64'(penable), 64'd0);
    consume();

    // Read: strobes must be zero despite a nonzero cmd_strb.
    prdata = 32'h0000_0003;
    issue(1'b0, 32'h0000_000C, 32'hFFFF_FFFF, 4'hF, 3'b000);
    check("rd_setup_pstrb", 64'(pstrb), 64'd0);
    check("rd_setup_pwrite", 64'(pwrite), 64'd0);
    tick();
    check("rd_access_pstrb", 64'(pstrb), 64'd0);
    tick();
    check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    check("rd_rsp_rdata", 64'(rsp_rdata), 64'h3);
    check("rd_rsp_err", 64'(rsp_err), 64'd0);
    consume();

    // Three wait states: four ACCESS cycles with stable outputs, response at N+6.
    pready = 1'b0;
    issue(1'b1, 32'h0000_0010, 32'hA5A5_0001, 4'h3, 3'b001);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ws_penable", 64'(penable), 64'd1);
      check("ws_paddr", 64'(paddr), 64'h10);
      check("ws_pwrite", 64'(pwrite), 64'd1);
      check("ws_pwdata", 64'(pwdata), 64'hA5A5_0001);
      check("ws_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    pready = 1'b1;
    tick();
    check("ws_rsp_valid_n6", 64'(rsp_valid), 64'd1);
    consume();

    // Slave error, response held to exercise backpressure.
    pslverr = 1'b1; prdata = 32'h0000_00AA;
    issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'b000);
    tick();
    tick();
    pslverr = 1'b0;
    check("err_rsp_valid", 64'(rsp_valid), 64'd1);
    check("err_rsp_err", 64'(rsp_err), 64'd1);
    check("err_rsp_rdata", 64'(rsp_rdata), 64'hAA);

    cmd_write = 1'b1; cmd_addr = 32'h0000_0044; cmd_wdata = 32'h0000_00FF;
    cmd_strb = 4'h1; cmd_prot = 3'b000; cmd_valid = 1'b1;
    check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    tick();
    check("bp_psel", 64'(psel), 64'd0);
    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    check("bp_rsp_err_stable", 64'(rsp_err), 64'd1);
    check("bp_rsp_rdata_stable", 64'(rsp_rdata), 64'hAA);
    rsp_ready = 1'b1;
    #1;
    check("b2b_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    check("b2b_rsp_valid", 64'(rsp_valid), 64'd0);
    check("b2b_psel", 64'(psel), 64'd1);
    check("b2b_penable", 64'(penable), 64'd0);
    check("b2b_paddr", 64'(paddr), 64'h44);
    tick();
    tick();
    check("good_rsp_valid", 64'(rsp_valid), 64'd1);
    check("good_rsp_err", 64'(rsp_err), 64'd0);
    consume();

    // Reset during ACCESS aborts at once and produces no response.
    pready = 1'b0;
    issue(1'b0, 32'h0000_0020, 32'h0, 4'h0, 3'b000);
    tick();
    check("mid_penable", 64'(penable), 64'd1);
    #2 preset = 1'b1;
    #1;
    check("mid_rst_psel", 64'(psel), 64'd0);
    check("mid_rst_penable", 64'(penable), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    preset = 1'b0; pready = 1'b1;
    tick();
    tick();
    check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("post_rst_psel", 64'(psel), 64'd0);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

`ifdef APB_MASTER_TIMEOUT_EN
    // Completer stuck: abandoned after four wait cycles with an error and zero data.
    pready = 1'b0; prdata = 32'hCAFE_F00D;
    issue(1'b0, 32'h0000_0080, 32'h0, 4'h0, 3'b000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_wait_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    tick();
    check("to_rsp_valid", 64'(rsp_valid), 64'd1);
    check("to_rsp_err", 64'(rsp_err), 64'd1);
    check("to_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("to_psel", 64'(psel), 64'd0);
    consume();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
